led_pulse_stretcher: RTL
========================

# led_pulse_stretcher

Output-side counterpart to the push-button debouncer. It turns single-cycle event pulses from core logic into LED flashes long enough for a person to see. Events that arrive during a flash are queued in a saturating counter and replayed in order, each as its own ON/GAP flash. It sits between design logic (for example a debounced `pbout`) and a board LED pin.

## Interface
- `CLK_DIV`, 250000, prescaler period in `clk` cycles (400 Hz tick at 100 MHz); minimum 2
- `ON_TICKS`, 40, LED-on duration in ticks; minimum 1
- `OFF_TICKS`, 40, forced dark gap after each flash, in ticks; minimum 1
- `PEND_W`, 4, width of the pending-event counter; maximum queued events = 2^PEND_W − 1

- `clk` in 1: system clock (100 MHz on board)
- `rst` in 1: synchronous, active-high reset
- `evt_in` in 1: event request; each `clk` cycle it is high counts as one event
- `clr_ovf` in 1: synchronous clear of `overflow`
- `led_out` out 1: LED drive, high during a flash
- `busy` out 1: high whenever the state is not IDLE
- `pending` out PEND_W: events queued and not yet started
- `overflow` out 1: sticky; set when an event is dropped

## Operation
- **Prescaler `pcnt`:** counts 0..CLK_DIV−1 while in ON or GAP. It is held at 0 in IDLE and forced to 0 on every IDLE→ON transition. `tick` is high for one cycle when `pcnt == CLK_DIV−1`.
- **Tick counter `tcnt`:** counts ticks within the current state and is cleared on every state change.
- **IDLE:** `led_out` = 0.
  - `evt_in` = 1 → ON next cycle. The event is consumed directly and `pending` is unchanged.
- **ON:** `led_out` = 1.
  - On `tick` with `tcnt == ON_TICKS−1` → GAP.
- **GAP:** `led_out` = 0.
  - On `tick` with `tcnt == OFF_TICKS−1`:
    - if `pending` ≠ 0 → ON, and `pending` is decremented;
    - else if `evt_in` = 1 → ON, and that event is consumed directly;
    - else → IDLE.
- **`pending` update:** applied every cycle.
  - +1 when `evt_in` = 1 and the event is not consumed directly (state ON or GAP, other than the GAP-exit case above).
  - −1 when a GAP→ON transition is taken from the queue.
  - +1 and −1 in the same cycle leave `pending` unchanged.
- **Saturation:**
  - An increment with `pending` = 2^PEND_W−1 and no simultaneous decrement is dropped.
  - In that case `pending` holds and `overflow` is set.
  - `pending` at maximum with both increment and decrement stays at maximum; `overflow` is not set.
- **`overflow`:** cleared by `clr_ovf`. If a set condition and `clr_ovf` occur in the same cycle, set wins.
- **`pending` in IDLE:** always 0. IDLE is entered only with an empty queue.
- **`busy`:** `busy` = (state ≠ IDLE).

## Timing
- All outputs are registered.
- **Reset values:** `led_out` 0, `busy` 0, `pending` 0, `overflow` 0, state IDLE, `pcnt` 0, `tcnt` 0.
- **Reset mid-flash:** the next cycle must be the reset state, with `led_out` low immediately. Queued events are discarded.
- **Start latency:** `evt_in` sampled high at edge n in IDLE → `led_out` high from cycle n+1.
- **Flash length:** `led_out` is high for exactly ON_TICKS·CLK_DIV cycles.
- **Gap length:** the gap is exactly OFF_TICKS·CLK_DIV cycles.
- **Queued events:** a queued event begins its flash in the cycle immediately after the gap ends. There are no idle cycles between queued flashes.
- **Worst-case count widths:**
  - `pcnt` is clog2(CLK_DIV) bits.
  - `tcnt` is clog2(max(ON_TICKS, OFF_TICKS)) bits.
  - Neither counter may wrap before its terminal compare.

## Test plan
Unless stated otherwise: CLK_DIV=4, ON_TICKS=3, OFF_TICKS=2, PEND_W=2.

- **Reset defaults:** hold `rst` 3 cycles, `evt_in` toggling → all outputs 0 throughout. First cycle after release: `led_out` = 0, `busy` = 0.
- **Single event:** one-cycle `evt_in` at cycle 10 → `led_out` high in cycles 11–22 (12 cycles), low in 23–30. `busy` is high in 11–30 and low at 31. `pending` stays 0.
- **Queued events:** `evt_in` pulses at cycles 10, 13 and 15 →
  - `pending` reads 1 at 14 and 2 at 16;
  - second flash 31–42 and third flash 51–62, with `pending` dropping to 1 at 31 and to 0 at 51;
  - `busy` falls at 71.
- **Saturation:** `evt_in` held high for 6 cycles starting in IDLE → 1 consumed directly, `pending` saturates at 3, `overflow` set. `clr_ovf` pulse → `overflow` 0; `pending` stays 3.
- **Simultaneous GAP exit:** `evt_in` high exactly on the final GAP tick with `pending` = 0 → direct GAP→ON with no IDLE cycle. `pending` stays 0 and `overflow` stays 0.
- **Reset mid-flash:** assert `rst` during the ON of the second of two queued flashes → `led_out` 0 and `pending` 0 next cycle. A new event afterward produces a full 12-cycle flash.

Source files
------------

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle event pulses into visible LED flashes (ON then forced dark GAP).
// Events arriving mid-flash are queued in a saturating counter and replayed back to back.
module led_pulse_stretcher #(
    parameter int CLK_DIV   = 250000,
    parameter int ON_TICKS  = 40,
    parameter int OFF_TICKS = 40,
    parameter int PEND_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              evt_in,
    input  logic              clr_ovf,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int PCNT_W = $clog2(CLK_DIV);
    localparam int TMAX   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TCNT_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(CLK_DIV - 1);
    localparam logic [TCNT_W-1:0] ON_LAST   = TCNT_W'(ON_TICKS - 1);
    localparam logic [TCNT_W-1:0] OFF_LAST  = TCNT_W'(OFF_TICKS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              led_q, busy_q;

    logic tick;
    logic on_done;
    logic gap_done;
    logic take_direct;
    logic take_queued;
    logic inc;
    logic ovf_set;

    assign tick     = (state_q != S_IDLE) && (pcnt_q == PCNT_LAST);
    assign on_done  = (state_q == S_ON)  && tick && (tcnt_q == ON_LAST);
    assign gap_done = (state_q == S_GAP) && tick && (tcnt_q == OFF_LAST);

    // At GAP exit the queue has priority; a fresh event is only consumed directly when the queue is empty.
    always_comb begin
        state_d     = state_q;
        take_direct = 1'b0;
        take_queued = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (evt_in) begin
                    state_d     = S_ON;
                    take_direct = 1'b1;
                end
            end
            S_ON: begin
                if (on_done) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    if (pending_q != '0) begin
                        state_d     = S_ON;
                        take_queued = 1'b1;
                    end else if (evt_in) begin
                        state_d     = S_ON;
                        take_direct = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pcnt_d = pcnt_q;
        if (state_q == S_IDLE || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PCNT_W'(1);
        end
    end

    always_comb begin
        tcnt_d = tcnt_q;
        if (state_d != state_q) begin
            tcnt_d = '0;
        end else if (tick) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end
    end

    // An increment and a decrement together cancel, so a full queue absorbs that case without overflowing.
    always_comb begin
        inc        = evt_in && !take_direct;
        ovf_set    = 1'b0;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (inc && !take_queued) begin
            if (pending_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (take_queued && !inc) begin
            pending_d = pending_q - PEND_W'(1);
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pcnt_q     <= '0;
            tcnt_q     <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            tcnt_q     <= tcnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            led_q      <= (state_d == S_ON);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign led_out  = led_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule
